// File: rtl/tl_cfg_sequencer_if.sv
// ============================================================================
// Module   : tl_cfg_sequencer_if
// Desc     : Bundle of the two configuration requester ports and the
//            command / status port of the traffic-light config sequencer.
//            Signal names carry the sequencer's own direction suffixes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tl_cfg_sequencer_if;
  // Requester 0
  logic        req0_valid_i;
  logic [1:0]  req0_field_i;
  logic [15:0] req0_data_i;
  logic        req0_ready_o;
  // Requester 1
  logic        req1_valid_i;
  logic [1:0]  req1_field_i;
  logic [15:0] req1_data_i;
  logic        req1_ready_o;
  // Command strobe towards the traffic light, plus status
  logic        cmd_valid_o;
  logic [2:0]  cmd_type_o;
  logic [15:0] cmd_data_o;
  logic        busy_o;
  logic        err_o;

  // Requester / light side: drives the write offers, observes everything else
  modport master (
    output req0_valid_i, req0_field_i, req0_data_i,
    output req1_valid_i, req1_field_i, req1_data_i,
    input  req0_ready_o, req1_ready_o,
    input  cmd_valid_o, cmd_type_o, cmd_data_o, busy_o, err_o
  );

  // Sequencer side
  modport slave (
    input  req0_valid_i, req0_field_i, req0_data_i,
    input  req1_valid_i, req1_field_i, req1_data_i,
    output req0_ready_o, req1_ready_o,
    output cmd_valid_o, cmd_type_o, cmd_data_o, busy_o, err_o
  );
endinterface

`default_nettype wire

// File: rtl/tl_cfg_sequencer.sv
// ============================================================================
// Module   : tl_cfg_sequencer
// Desc     : Serialises configuration writes from two requesters into a
//            paced command stream for a traffic light. The first write of a
//            batch puts the lights into yellow-blink, further writes arriving
//            within the batch window are issued without another blink, and
//            the lights are switched back on once the window expires.
//            Consecutive command strobes are always at least GAP_CYCLES apart.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tl_cfg_sequencer #(
  parameter int unsigned GAP_CYCLES   = 2,   // 1..255
  parameter int unsigned BATCH_WINDOW = 16   // GAP_CYCLES..65535
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  tl_cfg_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_ENTER  = 3'd2,
    S_GAP    = 3'd3,
    S_WRITE  = 3'd4,
    S_HOLD   = 3'd5,
    S_RESUME = 3'd6
  } state_e;

  localparam logic [2:0]  CMD_ON       = 3'd0;
  localparam logic [2:0]  CMD_BLINK    = 3'd2;
  localparam logic [2:0]  CMD_SET_BASE = 3'd3;   // field 0/1/2 -> 3/4/5
  localparam logic [1:0]  FLD_RSVD     = 2'd3;
  localparam logic [7:0]  GAP_LAST     = 8'(GAP_CYCLES - 1);
  localparam logic [15:0] HOLD_MIN     = 16'(GAP_CYCLES);
  localparam logic [15:0] HOLD_END     = 16'(BATCH_WINDOW);

  // Registered state
  state_e      state_q,     state_d;
  logic        init_arm_q,  init_arm_d;    // low only in the cycle right after reset
  logic        ret_write_q, ret_write_d;   // GAP return target: 1 = WRITE, 0 = IDLE
  logic [7:0]  gap_cnt_q,   gap_cnt_d;
  logic [15:0] hold_cnt_q,  hold_cnt_d;
  logic        ptr_q,       ptr_d;         // round-robin priority: 0 = requester 0
  logic [1:0]  fld_q,       fld_d;
  logic [15:0] data_q,      data_d;
  logic        err_q,       err_d;

  // Combinational decode
  logic        any_req;
  logic        pick0;
  logic        grant_en;
  logic        cmd_valid;
  logic [2:0]  cmd_type;
  logic [15:0] cmd_data;

  assign any_req = bus.req0_valid_i | bus.req1_valid_i;
  // Requester 0 wins when alone or when it holds priority on a tie
  assign pick0   = bus.req0_valid_i & (~bus.req1_valid_i | ~ptr_q);

  // State, capture and counter registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_INIT;
      init_arm_q  <= 1'b0;
      ret_write_q <= 1'b0;
      gap_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      ptr_q       <= 1'b0;
      fld_q       <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_arm_q  <= init_arm_d;
      ret_write_q <= ret_write_d;
      gap_cnt_q   <= gap_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      ptr_q       <= ptr_d;
      fld_q       <= fld_d;
      data_q      <= data_d;
      err_q       <= err_d;
    end
  end

  // Next-state, grant and command decode
  always_comb begin
    state_d     = state_q;
    init_arm_d  = 1'b1;
    ret_write_d = ret_write_q;
    gap_cnt_d   = gap_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    ptr_d       = ptr_q;
    fld_d       = fld_q;
    data_d      = data_q;
    err_d       = err_q;
    grant_en    = 1'b0;
    cmd_valid   = 1'b0;
    cmd_type    = CMD_ON;
    cmd_data    = '0;

    case (state_q)
      S_INIT: begin
        // INIT is held through reset with the strobe masked; the on/red
        // command fires in the first cycle after reset has been released.
        if (init_arm_q) begin
          cmd_valid   = 1'b1;
          cmd_type    = CMD_ON;
          state_d     = S_GAP;
          gap_cnt_d   = '0;
          ret_write_d = 1'b0;
        end
      end

      S_IDLE: begin
        if (any_req) begin
          grant_en = 1'b1;
          state_d  = S_ENTER;
        end
      end

      S_ENTER: begin
        cmd_valid   = 1'b1;
        cmd_type    = CMD_BLINK;
        state_d     = S_GAP;
        gap_cnt_d   = '0;
        ret_write_d = 1'b1;
      end

      S_GAP: begin
        if (gap_cnt_q >= GAP_LAST) begin
          state_d   = ret_write_q ? S_WRITE : S_IDLE;
          gap_cnt_d = '0;
        end else if (gap_cnt_q != 8'hFF) begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end

      S_WRITE: begin
        // A reserved-field write is swallowed: no command, only the error flag
        if (fld_q == FLD_RSVD) begin
          err_d = 1'b1;
        end else begin
          cmd_valid = 1'b1;
          cmd_type  = {1'b0, fld_q} + CMD_SET_BASE;
          cmd_data  = data_q;
        end
        state_d    = S_HOLD;
        hold_cnt_d = '0;
      end

      S_HOLD: begin
        if (hold_cnt_q != 16'hFFFF) begin
          hold_cnt_d = hold_cnt_q + 16'd1;
        end
        // A grant takes precedence over the window closing in the same cycle
        if ((hold_cnt_q >= HOLD_MIN) && any_req) begin
          grant_en = 1'b1;
          state_d  = S_WRITE;
        end else if (hold_cnt_q >= HOLD_END) begin
          state_d = S_RESUME;
        end
      end

      S_RESUME: begin
        cmd_valid   = 1'b1;
        cmd_type    = CMD_ON;
        state_d     = S_GAP;
        gap_cnt_d   = '0;
        ret_write_d = 1'b0;
      end

      default: begin
        state_d = S_INIT;
      end
    endcase

    // Capture the granted write and hand priority to the other requester
    if (grant_en) begin
      fld_d  = pick0 ? bus.req0_field_i : bus.req1_field_i;
      data_d = pick0 ? bus.req0_data_i  : bus.req1_data_i;
      ptr_d  = pick0;
    end
  end

  assign bus.req0_ready_o = grant_en &  pick0;
  assign bus.req1_ready_o = grant_en & ~pick0;
  assign bus.cmd_valid_o  = cmd_valid;
  assign bus.cmd_type_o   = cmd_type;
  assign bus.cmd_data_o   = cmd_data;
  assign bus.busy_o       = (state_q != S_IDLE);
  assign bus.err_o        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_tl_cfg_sequencer.sv
// ============================================================================
// Module   : tb_tl_cfg_sequencer
// Desc     : Directed self-checking bench for tl_cfg_sequencer. Command
//            strobes are logged with their cycle number and compared against
//            hand-computed sequences for each scenario.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tl_cfg_sequencer;

  localparam int GAP = 2;
  localparam int BW  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  tl_cfg_sequencer_if bus_if ();

  tl_cfg_sequencer #(
    .GAP_CYCLES   (GAP),
    .BATCH_WINDOW (BW)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // Command log and pacing monitor
  int log_cyc[$];
  int log_type[$];
  int log_data[$];
  int last_pulse = -1000;
  int gap_viol   = 0;

  always @(negedge clk) begin
    if (bus_if.cmd_valid_o) begin
      if (cyc - last_pulse - 1 < GAP) gap_viol <= gap_viol + 1;
      last_pulse <= cyc;
      log_cyc.push_back(cyc);
      log_type.push_back(int'(bus_if.cmd_type_o));
      log_data.push_back(int'(bus_if.cmd_data_o));
    end
  end

  // Offer writes from the enabled requesters (called right after a negedge);
  // returns the cycle in which each was granted.
  task automatic run_reqs(input bit en0, input logic [1:0] f0, input logic [15:0] d0,
                          input bit en1, input logic [1:0] f1, input logic [15:0] d1,
                          output int g0, output int g1);
    bit done0, done1;
    done0 = !en0; done1 = !en1; g0 = -1; g1 = -1;
    bus_if.req0_valid_i = en0; bus_if.req0_field_i = f0; bus_if.req0_data_i = d0;
    bus_if.req1_valid_i = en1; bus_if.req1_field_i = f1; bus_if.req1_data_i = d1;
    for (int k = 0; k < 80 && !(done0 && done1); k++) begin
      #1;
      if (!done0 && bus_if.req0_ready_o) begin g0 = cyc; done0 = 1'b1; end
      if (!done1 && bus_if.req1_ready_o) begin g1 = cyc; done1 = 1'b1; end
      @(negedge clk);
      if (done0) bus_if.req0_valid_i = 1'b0;
      if (done1) bus_if.req1_valid_i = 1'b0;
    end
    checks++;
    if (!(done0 && done1)) begin
      failures++;
      $display("FAIL grant_timeout: granted0=%0d granted1=%0d required both granted", done0, done1);
      bus_if.req0_valid_i = 1'b0;
      bus_if.req1_valid_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    int base, rel, first_idle, n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus_if.cmd_valid_o !== 1'b0) begin failures++; $display("FAIL rst_cmd_valid: got %0b want 0", bus_if.cmd_valid_o); end
    checks++; if (bus_if.cmd_type_o !== 3'd0) begin failures++; $display("FAIL rst_cmd_type: got %0d want 0", bus_if.cmd_type_o); end
    checks++; if (bus_if.cmd_data_o !== 16'd0) begin failures++; $display("FAIL rst_cmd_data: got %0d want 0", bus_if.cmd_data_o); end
    checks++; if ({bus_if.req0_ready_o, bus_if.req1_ready_o} !== 2'b00) begin failures++; $display("FAIL rst_ready: got %b want 00", {bus_if.req0_ready_o, bus_if.req1_ready_o}); end
    checks++; if (bus_if.busy_o !== 1'b1) begin failures++; $display("FAIL rst_busy: got %0b want 1", bus_if.busy_o); end
    checks++; if (bus_if.err_o !== 1'b0) begin failures++; $display("FAIL rst_err: got %0b want 0", bus_if.err_o); end
    base = log_cyc.size();
    rst_n = 1'b1;
    rel = cyc;
    first_idle = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (first_idle < 0 && bus_if.busy_o === 1'b0) first_idle = cyc;
    end
    n = log_cyc.size() - base;
    checks++; if (n !== 1) begin failures++; $display("FAIL init_cmd_count: got %0d want 1", n); end
    if (n >= 1) begin
      checks++;
      if (log_cyc[base] !== rel + 1 || log_type[base] !== 0 || log_data[base] !== 0) begin
        failures++;
        $display("FAIL init_cmd: got cyc=%0d type=%0d data=%0d want cyc=%0d type=0 data=0",
                 log_cyc[base] - rel, log_type[base], log_data[base], 1);
      end
    end
    checks++; if (first_idle !== rel + 2 + GAP) begin failures++; $display("FAIL init_busy_fall: got %0d want %0d", first_idle - rel, 2 + GAP); end
  endtask

  task automatic test_single_write();
    int base, a, t, g0, g1, n, first_idle;
    int ec[3], et[3], ed[3];
    base = log_cyc.size();
    a = cyc;
    run_reqs(1'b1, 2'd1, 16'd200, 1'b0, 2'd0, 16'd0, g0, g1);
    t = g0;
    checks++; if (g0 !== a) begin failures++; $display("FAIL single_grant_cycle: got %0d want %0d", g0 - a, 0); end
    first_idle = -1;
    for (int k = 0; k < 29; k++) begin
      @(negedge clk);
      if (first_idle < 0 && bus_if.busy_o === 1'b0) first_idle = cyc;
    end
    ec = '{t + 1, t + 2 + GAP, t + 4 + GAP + BW};
    et = '{2, 4, 0};
    ed = '{0, 200, 0};
    n = log_cyc.size() - base;
    checks++; if (n !== 3) begin failures++; $display("FAIL single_cmd_count: got %0d want 3", n); end
    for (int i = 0; i < 3 && i < n; i++) begin
      checks++;
      if (log_cyc[base+i] !== ec[i] || log_type[base+i] !== et[i] || log_data[base+i] !== ed[i]) begin
        failures++;
        $display("FAIL single_cmd%0d: got cyc=+%0d type=%0d data=%0d want cyc=+%0d type=%0d data=%0d",
                 i, log_cyc[base+i] - t, log_type[base+i], log_data[base+i], ec[i] - t, et[i], ed[i]);
      end
    end
    checks++; if (first_idle !== t + 5 + 2*GAP + BW) begin failures++; $display("FAIL single_busy_fall: got +%0d want +%0d", first_idle - t, 5 + 2*GAP + BW); end
  endtask

  task automatic test_back_to_back();
    int base, a, t, g0, g1, n;
    int ec[4], et[4], ed[4];
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    base = log_cyc.size();
    a = cyc;
    run_reqs(1'b1, 2'd0, 16'd1000, 1'b1, 2'd2, 16'h1234, g0, g1);
    t = g0;
    checks++; if (g0 !== a) begin failures++; $display("FAIL b2b_req0_first: got +%0d want +0", g0 - a); end
    checks++; if (g1 !== t + 3 + 2*GAP) begin failures++; $display("FAIL b2b_req1_hold_grant: got +%0d want +%0d", g1 - t, 3 + 2*GAP); end
    repeat (26) @(negedge clk);
    ec = '{t + 1, t + 2 + GAP, t + 4 + 2*GAP, t + 6 + 2*GAP + BW};
    et = '{2, 3, 5, 0};
    ed = '{0, 1000, 'h1234, 0};
    n = log_cyc.size() - base;
    checks++; if (n !== 4) begin failures++; $display("FAIL b2b_cmd_count: got %0d want 4", n); end
    for (int i = 0; i < 4 && i < n; i++) begin
      checks++;
      if (log_cyc[base+i] !== ec[i] || log_type[base+i] !== et[i] || log_data[base+i] !== ed[i]) begin
        failures++;
        $display("FAIL b2b_cmd%0d: got cyc=+%0d type=%0d data=%0d want cyc=+%0d type=%0d data=%0d",
                 i, log_cyc[base+i] - t, log_type[base+i], log_data[base+i], ec[i] - t, et[i], ed[i]);
      end
    end
  endtask

  task automatic test_field3();
    int base, t, g0, g1, n;
    int ec[2], et[2];
    base = log_cyc.size();
    checks++; if (bus_if.err_o !== 1'b0) begin failures++; $display("FAIL f3_err_before: got %0b want 0", bus_if.err_o); end
    run_reqs(1'b1, 2'd3, 16'd55, 1'b0, 2'd0, 16'd0, g0, g1);
    t = g0;
    repeat (3) @(negedge clk);
    checks++; if (bus_if.err_o !== 1'b0) begin failures++; $display("FAIL f3_err_early: got %0b want 0", bus_if.err_o); end
    @(negedge clk);
    checks++; if (bus_if.err_o !== 1'b1) begin failures++; $display("FAIL f3_err_set: got %0b want 1", bus_if.err_o); end
    repeat (25) @(negedge clk);
    checks++; if (bus_if.err_o !== 1'b1) begin failures++; $display("FAIL f3_err_sticky: got %0b want 1", bus_if.err_o); end
    ec = '{t + 1, t + 4 + GAP + BW};
    et = '{2, 0};
    n = log_cyc.size() - base;
    checks++; if (n !== 2) begin failures++; $display("FAIL f3_cmd_count: got %0d want 2", n); end
    for (int i = 0; i < 2 && i < n; i++) begin
      checks++;
      if (log_cyc[base+i] !== ec[i] || log_type[base+i] !== et[i] || log_data[base+i] !== 0) begin
        failures++;
        $display("FAIL f3_cmd%0d: got cyc=+%0d type=%0d data=%0d want cyc=+%0d type=%0d data=0",
                 i, log_cyc[base+i] - t, log_type[base+i], log_data[base+i], ec[i] - t, et[i]);
      end
    end
  endtask

  task automatic test_reset_in_hold();
    int base, rel, g0, g1, n;
    run_reqs(1'b0, 2'd0, 16'd0, 1'b1, 2'd0, 16'd7, g0, g1);
    repeat (5) @(negedge clk);
    checks++; if (bus_if.busy_o !== 1'b1) begin failures++; $display("FAIL rih_busy_hold: got %0b want 1", bus_if.busy_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus_if.cmd_valid_o !== 1'b0) begin failures++; $display("FAIL rih_cmd_valid: got %0b want 0", bus_if.cmd_valid_o); end
    checks++; if (bus_if.busy_o !== 1'b1) begin failures++; $display("FAIL rih_busy: got %0b want 1", bus_if.busy_o); end
    checks++; if (bus_if.err_o !== 1'b0) begin failures++; $display("FAIL rih_err_async: got %0b want 0", bus_if.err_o); end
    repeat (2) @(negedge clk);
    base = log_cyc.size();
    rst_n = 1'b1;
    rel = cyc;
    repeat (25) @(negedge clk);
    n = log_cyc.size() - base;
    checks++; if (n !== 1) begin failures++; $display("FAIL rih_cmd_count: got %0d want 1", n); end
    if (n >= 1) begin
      checks++;
      if (log_cyc[base] !== rel + 1 || log_type[base] !== 0) begin
        failures++;
        $display("FAIL rih_init_cmd: got cyc=+%0d type=%0d want cyc=+1 type=0", log_cyc[base] - rel, log_type[base]);
      end
    end
  endtask

  task automatic test_late_grant();
    int base, t, g0, g1, h0, h1, n;
    int ec[4], et[4], ed[4];
    base = log_cyc.size();
    run_reqs(1'b1, 2'd2, 16'd300, 1'b0, 2'd0, 16'd0, g0, g1);
    t = g0;
    while (cyc < t + 3 + GAP + BW) @(negedge clk);
    run_reqs(1'b0, 2'd0, 16'd0, 1'b1, 2'd1, 16'd999, h0, h1);
    checks++; if (h1 !== t + 3 + GAP + BW) begin failures++; $display("FAIL late_grant_cycle: got +%0d want +%0d", h1 - t, 3 + GAP + BW); end
    repeat (30) @(negedge clk);
    ec = '{t + 1, t + 2 + GAP, t + 4 + GAP + BW, t + 6 + GAP + 2*BW};
    et = '{2, 5, 4, 0};
    ed = '{0, 300, 999, 0};
    n = log_cyc.size() - base;
    checks++; if (n !== 4) begin failures++; $display("FAIL late_cmd_count: got %0d want 4", n); end
    for (int i = 0; i < 4 && i < n; i++) begin
      checks++;
      if (log_cyc[base+i] !== ec[i] || log_type[base+i] !== et[i] || log_data[base+i] !== ed[i]) begin
        failures++;
        $display("FAIL late_cmd%0d: got cyc=+%0d type=%0d data=%0d want cyc=+%0d type=%0d data=%0d",
                 i, log_cyc[base+i] - t, log_type[base+i], log_data[base+i], ec[i] - t, et[i], ed[i]);
      end
    end
    checks++; if (gap_viol !== 0) begin failures++; $display("FAIL cmd_spacing: got %0d short gaps want 0", gap_viol); end
  endtask

  initial begin
    bus_if.req0_valid_i = 1'b0;
    bus_if.req0_field_i = 2'd0;
    bus_if.req0_data_i  = 16'd0;
    bus_if.req1_valid_i = 1'b0;
    bus_if.req1_field_i = 2'd0;
    bus_if.req1_data_i  = 16'd0;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_field3();
    test_reset_in_hold();
    test_late_grant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/tl_cfg_sequencer.md
TL_CFG_SEQUENCER -- requirements
Module: tl_cfg_sequencer

Interface
REQ-001 Parameter GAP_CYCLES, default 2: minimum idle cycles between two consecutive cmd_valid_o pulses; legal range 1..255.
REQ-002 Parameter BATCH_WINDOW, default 16: cycles the lights stay in yellow-blink waiting for further writes; legal range GAP_CYCLES..65535.
REQ-003 clk_i  input  1  single clock; all logic on posedge.
REQ-004 rst_n_i  input  1  reset, asynchronous and active-low.
REQ-005 reqN_valid_i  input  1  (N=0,1) requester N offers a configuration write.
REQ-006 reqN_field_i  input  2  (N=0,1) field: 0 green time, 1 red time, 2 yellow time, 3 reserved.
REQ-007 reqN_data_i  input  16  (N=0,1) time value in ms, passed through unchanged.
REQ-008 reqN_ready_o  output  1  (N=0,1) one-cycle accept pulse; a write transfers when valid and ready are both high.
REQ-009 cmd_valid_o  output  1  one-cycle command strobe to the traffic light.
REQ-010 cmd_type_o  output  3  command code: 0 on/red, 2 yellow-blink, 3 set green, 4 set red, 5 set yellow; code 1 is never issued.
REQ-011 cmd_data_o  output  16  command data; 0 unless cmd_type_o is 3, 4 or 5.
REQ-012 busy_o  output  1  high in every state except IDLE.
REQ-013 err_o  output  1  sticky flag; set when a field-3 write is accepted.

Function
REQ-014 States: INIT, IDLE, ENTER, GAP, WRITE, HOLD, RESUME.
REQ-015 INIT is entered on reset, drives cmd_valid_o=1 with type 0 for one cycle, then goes to GAP with return target IDLE.
REQ-016 In IDLE, if any reqN_valid_i is high, assert ready for exactly one requester in that cycle, capture its field and data, then go to ENTER.
REQ-017 Arbitration is round-robin with a 1-bit pointer that resets to requester 0; on a tie the pointer's requester wins, and the pointer moves to the other requester after every grant.
REQ-018 A lone valid requester is granted regardless of the pointer.
REQ-019 ENTER issues type 2 for one cycle, then goes to GAP with return target WRITE.
REQ-020 GAP holds cmd_valid_o=0 for exactly GAP_CYCLES cycles, then goes to its return target.
REQ-021 WRITE issues the captured field plus 3 (type 3/4/5) with the captured data for one cycle, then goes to HOLD with hold counter = 0.
REQ-022 If the captured field is 3, WRITE issues no command, sets err_o, and still goes to HOLD.
REQ-023 HOLD increments the hold counter every cycle; cmd_valid_o=0 throughout.
REQ-024 In HOLD, while hold counter >= GAP_CYCLES and a request is valid: grant per REQ-017/018, capture it, and go to WRITE with no second ENTER.
REQ-025 In HOLD, if hold counter reaches BATCH_WINDOW with no grant, go to RESUME; if a grant and the window end coincide, the grant wins.
REQ-026 RESUME issues type 0 for one cycle, then goes to GAP with return target IDLE.
REQ-027 reqN_ready_o is asserted only in IDLE or an eligible HOLD cycle; otherwise it is 0.
REQ-028 Requests arriving during INIT, ENTER, GAP, WRITE or RESUME wait, and valid may stay high.
REQ-029 Command latency: grant in IDLE at cycle t gives ENTER at t+1 and WRITE at t+2+GAP_CYCLES.
REQ-030 Any two cmd_valid_o pulses are separated by at least GAP_CYCLES zero cycles.
REQ-031 Counters saturate and never wrap; the hold counter is 16 bits wide.

Reset
REQ-032 Asserting rst_n_i low immediately forces cmd_valid_o=0, cmd_type_o=0, cmd_data_o=0, ready=0, busy_o=1, err_o=0, pointer=0, all counters 0, and state INIT.
REQ-033 A reset mid-sequence (lights in blink) is recovered by the INIT type-0 command after release.
REQ-034 Captured requests not yet issued are lost on reset.

Verification
REQ-035 Reset release with no requests -> one cmd_valid_o with type 0 in the first cycle, then busy_o falls after GAP_CYCLES; no other commands.
REQ-036 One req0 write (field 1, data 200) -> command sequence type 2; type 4 with data 200; after 16 hold cycles type 0; gaps >= 2 cycles.
REQ-037 req0 and req1 both valid in IDLE after reset -> req0 granted first; req1 granted in HOLD at hold count 2; commands type 2, 3/4/5, 3/4/5, 0 with only one type 2.
REQ-038 A field-3 write -> err_o goes high and stays high, sequence type 2 then type 0, with no set command.
REQ-039 rst_n_i pulsed low during HOLD -> outputs 0 asynchronously; after release a type-0 command is issued.
REQ-040 A request arriving at hold count = BATCH_WINDOW -> granted, no RESUME before its WRITE.
